// File: rtl/multichannel_delay_ring_pkg.sv
// Shared defaults and helpers for the audio effects datapath.
package audio_dsp_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 7;

  typedef logic [DATA_W_DEFAULT-1:0] sample_t;

  // Channel-select width; a single channel still gets a 1-bit field.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/multichannel_delay_ring_ram.sv
// Simple dual-port RAM: synchronous write, registered read, old data on
// read-during-write to the same word.
module ring_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/multichannel_delay_ring.sv
// Multi-channel circular sample store with a programmable ring length and
// delay-addressed, zero-masked reads through a 2-stage pipeline.
module multichannel_delay_ring
  import audio_dsp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int CHANNELS = 2,
  localparam int CH_W    = ch_w(CHANNELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] cur_addr,
  input  logic              wr_valid,
  input  logic [CH_W-1:0]   wr_chan,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_chan,
  input  logic [ADDR_W-1:0] rd_delay,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   fill
);

  localparam int PA_W = CH_W + ADDR_W;

  logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
  logic [ADDR_W:0]   fill_reg, fill_next;
  logic [ADDR_W:0]   ring_len, fill_sat;
  logic              wr_ok, commit;

  logic [ADDR_W-1:0] newest, delay_clamped, rd_index;
  logic              rd_mask;

  logic              s1_valid_reg, s1_mask_reg;
  logic [PA_W-1:0]   s1_addr_reg;
  logic              s2_valid_reg, s2_mask_reg;
  logic [DATA_W-1:0] ram_q;

  always_comb begin
    wr_ok    = wr_valid && !reset && (int'(wr_chan) < CHANNELS);
    commit   = wr_ok && (int'(wr_chan) == CHANNELS - 1);
    ring_len = {1'b0, last_addr} + (ADDR_W+1)'(1);
    // fill is never rescaled on a shrink, so clamp it where it is consumed.
    fill_sat = (fill_reg > ring_len) ? ring_len : fill_reg;

    cur_addr_next = (cur_addr_reg >= last_addr) ? '0 : cur_addr_reg + ADDR_W'(1);
    fill_next     = (fill_reg < ring_len) ? fill_reg + (ADDR_W+1)'(1) : fill_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr_reg <= '0;
      fill_reg     <= '0;
    end else if (commit) begin
      cur_addr_reg <= cur_addr_next;
      fill_reg     <= fill_next;
    end
  end

  // Modular arithmetic at ADDR_W bits equals the wide sum truncated.
  always_comb begin
    newest        = (cur_addr_reg == '0) ? last_addr : cur_addr_reg - ADDR_W'(1);
    delay_clamped = (rd_delay > last_addr) ? last_addr : rd_delay;
    rd_index      = (newest >= delay_clamped) ? newest - delay_clamped
                                              : newest + last_addr + ADDR_W'(1) - delay_clamped;
    rd_mask       = ({1'b0, delay_clamped} >= fill_sat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= rd_req;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    s1_addr_reg <= {rd_chan, rd_index};
    s1_mask_reg <= rd_mask;
    s2_mask_reg <= s1_mask_reg;
  end

  ring_ram #(
    .WIDTH (DATA_W),
    .AW    (PA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr ({wr_chan, cur_addr_reg}),
    .wdata (wr_data),
    .re    (s1_valid_reg),
    .raddr (s1_addr_reg),
    .rdata (ram_q)
  );

  assign cur_addr = cur_addr_reg;
  assign fill     = fill_reg;
  assign rd_valid = s2_valid_reg;
  assign rd_data  = (s2_valid_reg && !s2_mask_reg) ? ram_q : '0;

endmodule

// File: tb/tb_multichannel_delay_ring.sv
// Scoreboard bench: stimulus pushes expected reads, a monitor pops them.
module tb_multichannel_delay_ring;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CH = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] last_addr = 4'd15;
  logic [AW-1:0] cur_addr;
  logic          wr_valid = 1'b0;
  logic [CW-1:0] wr_chan = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic [CW-1:0] rd_chan = '0;
  logic [AW-1:0] rd_delay = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW:0]   fill;

  multichannel_delay_ring #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .CHANNELS (CH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .last_addr (last_addr),
    .cur_addr  (cur_addr),
    .wr_valid  (wr_valid),
    .wr_chan   (wr_chan),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_chan   (rd_chan),
    .rd_delay  (rd_delay),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
    int            ch;
    int            dly;
  } exp_t;
  exp_t sb[$];

  // Reference state: ring pointer, frame count and per-channel history.
  int            m_cur = 0;
  int            m_fill = 0;
  logic [DW-1:0] m_mem [CH][1<<AW];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got data=%h with no read outstanding (cycle %0d)", rd_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.due != cyc || rd_data !== e.data) begin
          failures++;
          $display("FAIL rd_data ch=%0d delay=%0d got=%h at cycle %0d expected=%h at cycle %0d",
                   e.ch, e.dly, rd_data, cyc, e.data, e.due);
        end else begin
          $display("read ch=%0d delay=%0d data=%h", e.ch, e.dly, rd_data);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL rd_missing ch=%0d delay=%0d got rd_valid=%b expected=1 at cycle %0d",
               e.ch, e.dly, rd_valid, e.due);
    end
  end

  // One clock of stimulus; called just after a falling edge.
  task automatic step(input bit rst, input bit wv, input int wch, input logic [DW-1:0] wd,
                      input bit rr, input int rch, input int rdel);
    int   la, len, fs, d, newest, idx;
    bit   masked;
    exp_t e;
    reset    = rst;
    wr_valid = wv;
    wr_chan  = CW'(wch);
    wr_data  = wd;
    rd_req   = rr;
    rd_chan  = CW'(rch);
    rd_delay = AW'(rdel);

    la     = int'(last_addr);
    len    = la + 1;
    fs     = (m_fill < len) ? m_fill : len;
    d      = (rdel < la) ? rdel : la;
    newest = (m_cur == 0) ? la : m_cur - 1;
    idx    = (newest >= d) ? newest - d : (newest + len - d) % (1 << AW);
    masked = (d >= fs);

    if (rst) begin
      sb.delete();
      m_cur  = 0;
      m_fill = 0;
    end else if (wv && wch < CH) begin
      m_mem[wch][m_cur] = wd;
      if (wch == CH - 1) begin
        m_cur = (m_cur >= la) ? 0 : m_cur + 1;
        if (m_fill < len) m_fill++;
      end
    end

    // The RAM is read one edge after the request, so this cycle's write is visible.
    if (rr && !rst) begin
      e.data = masked ? '0 : m_mem[rch][idx];
      e.due  = cyc + 2;
      e.ch   = rch;
      e.dly  = rdel;
      sb.push_back(e);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("cur_addr", int'(cur_addr), m_cur);
    chk("fill", int'(fill), m_fill);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic rd(input int ch, input int dly);
    step(0, 0, 0, '0, 1, ch, dly);
  endtask

  task automatic frame(input logic [DW-1:0] base);
    for (int c = 0; c < CH; c++)
      step(0, 1, c, base + DW'(c) * 16'h100, 0, 0, 0);
  endtask

  int cur_seq [6] = '{1, 2, 3, 0, 1, 2};

  initial begin
    @(negedge clk);
    #1;
    // Reset state and a silent first read.
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, 0, 0);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    rd(0, 0);
    repeat (3) idle();

    // Fill every word once so later reads never touch uninitialised RAM.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0)
          step(0, 1, 3, DW'($urandom), 1, $urandom_range(0, 2), $urandom_range(0, 15));
        step(0, 1, c, DW'($urandom), 1, $urandom_range(0, 2), $urandom_range(0, 15));
      end
    end

    // Six frames on a 4-frame ring.
    last_addr = 4'd3;
    step(1, 0, 0, '0, 0, 0, 0);
    for (int n = 1; n <= 6; n++) begin
      frame(DW'(16'h100 + n));
      chk("cur_seq", int'(cur_addr), cur_seq[n-1]);
    end
    chk("fill_sat", int'(fill), 4);
    rd(1, 0);
    rd(0, 3);
    rd(0, 10);
    rd(2, 2);

    // History shorter than the requested delay reads as zero.
    step(1, 0, 0, '0, 0, 0, 0);
    frame(16'h0111);
    frame(16'h0122);
    rd(0, 2);
    rd(0, 1);
    rd(1, 0);

    // Read in the commit cycle sees the previous frame; the next read sees the new one.
    step(0, 1, 0, 16'h0aaa, 0, 0, 0);
    step(0, 1, 1, 16'h0bbb, 0, 0, 0);
    step(0, 1, 2, 16'h0ccc, 1, 2, 0);
    rd(2, 0);
    repeat (2) idle();

    // Shrink the ring while the pointer is beyond the new end.
    last_addr = 4'd7;
    step(1, 0, 0, '0, 0, 0, 0);
    for (int n = 0; n < 5; n++) frame(DW'(16'h0400 + n));
    chk("pre_shrink_cur", int'(cur_addr), 5);
    last_addr = 4'd2;
    frame(16'h0455);
    chk("post_shrink_cur", int'(cur_addr), 0);
    for (int dl = 0; dl < 5; dl++) rd(dl % CH, dl);
    frame(16'h0466);
    for (int dl = 0; dl < 4; dl++) rd(1, dl);

    // Randomised traffic with occasional ring-length changes and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) last_addr = AW'($urandom_range(0, 15));
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 3), DW'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 2), $urandom_range(0, 15));
    end
    repeat (3) idle();

    // Reset with reads in flight drops them.
    last_addr = 4'd5;
    frame(16'h0777);
    rd(0, 0);
    rd(1, 0);
    step(1, 0, 0, '0, 1, 2, 0);
    idle();
    idle();
    chk("flush_rd_valid", int'(rd_valid), 0);
    chk("flush_rd_data", int'(rd_data), 0);
    repeat (3) idle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
